// File: rtl/mult_pkg.sv
// Shared widths, limits and FSM encoding for the multiplier arbiter slice.
package mult_pkg;
  localparam int OP_W     = 32;
  localparam int RES_W    = 64;
  localparam int NREQ_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mult_arbiter_if.sv
// Request fan-in and response channel between requesters and the shared multiplier.
interface mult_arbiter_if
  import mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*OP_W-1:0] req_op0;
  logic [NREQ*OP_W-1:0] req_op1;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [RES_W-1:0]     rsp_res;
  logic                 busy;

  modport master (
    output req_valid, req_op0, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res, busy
  );

  modport slave (
    input  req_valid, req_op0, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res, busy
  );
endinterface

// File: rtl/multipler.sv
// Existing 32x32 unsigned combinational multiplier; zero latency, no flow control.
module multipler
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [RES_W-1:0] p
);
  assign p = RES_W'(a) * RES_W'(b);
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier, flopped on both sides; grant to rsp_valid is 2 cycles.
// While rsp_ready is low the response holds steady and no new request is granted.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic           clk,
  input logic           rst,
  mult_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr, id_q, gnt_idx;
  logic              gnt_any;
  logic [NREQ-1:0]   req_ready_d;
  logic [OP_W-1:0]   a_q, b_q;
  logic [RES_W-1:0]  prod, res_q;

  // Returns {found, index}: first set bit at or above ptr, wrapping past NREQ-1.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                           input logic [IDW-1:0]  ptr);
    logic           found;
    logic [IDW-1:0] idx;
    int             j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && vld[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
    return {found, idx};
  endfunction

  assign {gnt_any, gnt_idx} = rr_pick(bus.req_valid, rr_ptr);

  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    case (state_q)
      IDLE: begin
        // A grant asserted during reset would be a handshake that is never honoured.
        if (gnt_any && !rst) begin
          req_ready_d[gnt_idx] = 1'b1;
          state_d              = MUL;
        end
      end
      MUL:     state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_d;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_res   = res_q;
  assign bus.busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_any) begin
        a_q    <= bus.req_op0[gnt_idx*OP_W +: OP_W];
        b_q    <= bus.req_op1[gnt_idx*OP_W +: OP_W];
        id_q   <= gnt_idx;
        rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
      end
      if (state_q == MUL) res_q <= prod;
    end
  end

  multipler u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and random checks of mult_arbiter against a transaction-level model.
module tb_mult_arbiter;
  import mult_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic [63:0] res;
    int          gcyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          m_ptr  = 0;
  int          outstanding = 0;
  int          n_xfer = 0;
  int          last_gnt_cyc = 0;
  logic        front_seen = 1'b0;
  logic [63:0] last_res;
  logic [63:0] last_id;
  exp_t        exp_q[$];
  logic [31:0] a_arr[NREQ];
  logic [31:0] b_arr[NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] vld);
    for (int k = 0; k < NREQ; k++)
      if (vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op0[32*i +: 32] = a_arr[i];
      bus.req_op1[32*i +: 32] = b_arr[i];
    end
  endtask

  // Compares one settled cycle against the model and advances the model.
  task automatic monitor(output int g);
    int              p;
    logic [NREQ-1:0] er;
    g  = -1;
    p  = (outstanding == 0) ? model_pick(bus.req_valid) : -1;
    er = (p >= 0) ? (NREQ'(1) << p) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("busy", 64'(bus.busy), 64'(outstanding != 0));
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        if (!front_seen) begin
          chk("rsp_latency", 64'(cyc - exp_q[0].gcyc), 64'd2);
          front_seen = 1'b1;
        end
        chk("rsp_id", 64'(bus.rsp_id), 64'(exp_q[0].id));
        chk("rsp_res", bus.rsp_res, exp_q[0].res);
        if (bus.rsp_ready) begin
          last_id  = 64'(bus.rsp_id);
          last_res = bus.rsp_res;
          n_xfer++;
          void'(exp_q.pop_front());
          front_seen  = 1'b0;
          outstanding = 0;
        end
      end
    end else if (exp_q.size() > 0 && cyc >= exp_q[0].gcyc + 2) begin
      chk("rsp_missing", 64'(bus.rsp_valid), 64'd1);
    end
    if (p >= 0) begin
      exp_q.push_back('{id: p, res: ref_prod(a_arr[p], b_arr[p]), gcyc: cyc});
      m_ptr        = (p + 1) % NREQ;
      outstanding  = 1;
      last_gnt_cyc = cyc;
      g            = p;
    end
  endtask

  task automatic sample(output int g);
    drive_ops();
    #1;
    monitor(g);
  endtask

  task automatic step(output int g);
    sample(g);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
    m_ptr = 0;
    outstanding = 0;
    exp_q.delete();
    front_seen = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    int g;
    while ((exp_q.size() > 0 || bus.req_valid != '0) && n < 40) begin
      step(g);
      if (g >= 0) bus.req_valid[g] = 1'b0;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_txn(input int idx, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    int g = -1;
    a_arr[idx] = a;
    b_arr[idx] = b;
    bus.req_valid[idx] = 1'b1;
    while (g < 0 && n < 20) begin
      step(g);
      n++;
    end
    chk("txn_grant", 64'(g), 64'(idx));
    bus.req_valid[idx] = 1'b0;
    drain();
  endtask

  initial begin
    int g, n, grants, prev_gnt, issued, xfer0, soak_cycles;
    logic [31:0] a0, b0;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    drive_ops();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("reset_rsp_res", bus.rsp_res, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);

    // Single request 2 * (7, 9)
    bus.rsp_ready = 1'b1;
    a_arr[2] = 32'd7;
    b_arr[2] = 32'd9;
    bus.req_valid = 4'b0100;
    sample(g);
    chk("single_grant", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid = '0;
    sample(g);
    chk("single_t1_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    sample(g);
    chk("single_t2_valid", 64'(bus.rsp_valid), 64'd1);
    chk("single_t2_id", 64'(bus.rsp_id), 64'd2);
    chk("single_t2_res", bus.rsp_res, 64'd63);
    tick();
    sample(g);
    chk("single_t3_idle", 64'(bus.busy), 64'd0);
    tick();

    // Corner operands
    do_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("corner_max", last_res, 64'hFFFF_FFFE_0000_0001);
    do_txn(1, 32'h8000_0000, 32'd2);
    chk("corner_shift", last_res, 64'h1_0000_0000);
    do_txn(3, 32'd0, 32'h1234_5678);
    chk("corner_zero", last_res, 64'd0);

    // Round-robin with every requester always pending
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = $urandom;
      b_arr[i] = $urandom;
    end
    bus.req_valid = '1;
    grants = 0;
    prev_gnt = -1;
    n = 0;
    while (grants < 6 && n < 60) begin
      step(g);
      if (g >= 0) begin
        chk("rr_order", 64'(g), 64'(grants % NREQ));
        if (prev_gnt >= 0) chk("rr_spacing", 64'(last_gnt_cyc - prev_gnt), 64'd3);
        prev_gnt = last_gnt_cyc;
        grants++;
        a_arr[g] = $urandom;
        b_arr[g] = $urandom;
      end
      n++;
    end
    chk("rr_grants", 64'(grants), 64'd6);
    bus.req_valid = '0;
    drain();

    // Backpressure: five RESP cycles with rsp_ready low and req 1 waiting
    bus.rsp_ready = 1'b0;
    a0 = $urandom;
    b0 = $urandom;
    a_arr[0] = a0;
    b_arr[0] = b0;
    bus.req_valid[0] = 1'b1;
    g = -1;
    n = 0;
    while (g < 0 && n < 10) begin
      step(g);
      n++;
    end
    chk("bp_grant", 64'(g), 64'd0);
    bus.req_valid[0] = 1'b0;
    a_arr[1] = $urandom;
    b_arr[1] = $urandom;
    bus.req_valid[1] = 1'b1;
    step(g);
    for (int k = 0; k < 5; k++) begin
      sample(g);
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_id", 64'(bus.rsp_id), 64'd0);
      chk("bp_res", bus.rsp_res, ref_prod(a0, b0));
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    step(g);
    sample(g);
    chk("bp_next_grant", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    if (g >= 0) bus.req_valid[g] = 1'b0;
    drain();

    // Reset while the multiply is in flight
    a_arr[2] = 32'd5;
    b_arr[2] = 32'd6;
    bus.req_valid[2] = 1'b1;
    g = -1;
    n = 0;
    while (g < 0 && n < 10) begin
      step(g);
      n++;
    end
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = 0;
    outstanding = 0;
    exp_q.delete();
    front_seen = 1'b0;
    #1;
    chk("mrst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mrst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("mrst_rsp_res", bus.rsp_res, 64'd0);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    tick();
    sample(g);
    chk("mrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    tick();
    a_arr[1] = $urandom;
    b_arr[1] = $urandom;
    a_arr[3] = $urandom;
    b_arr[3] = $urandom;
    bus.req_valid = 4'b1010;
    sample(g);
    chk("mrst_next_grant", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    if (g >= 0) bus.req_valid[g] = 1'b0;
    drain();

    // Random soak
    do_reset();
    issued = 0;
    xfer0 = n_xfer;
    soak_cycles = 0;
    while ((n_xfer - xfer0) < 10000 && soak_cycles < 80000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && issued < 10000 && $urandom_range(0, 2) == 0) begin
          a_arr[i] = rnd_op();
          b_arr[i] = rnd_op();
          bus.req_valid[i] = 1'b1;
          issued++;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step(g);
      if (g >= 0) bus.req_valid[g] = 1'b0;
      soak_cycles++;
    end
    chk("soak_xfers", 64'(n_xfer - xfer0), 64'd10000);
    chk("soak_leftover", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
